// File: rtl/spmv_pkg.sv
// spmv_pkg: shared state type, lane-mask and saturation helpers for the CSR SpMV row engine
package spmv_pkg;
  localparam int MAX_LANES = 64;
  localparam int SAT_W = 128;
  typedef enum logic [2:0] {IDLE, PTR0, PTR, ISSUE, DRAIN, WRITE} spmv_engine_state_e;
  function automatic logic [MAX_LANES-1:0] lane_mask(input int len_mod, input int p);
    lane_mask = '0;
    for (int i = 0; i < MAX_LANES; i++) lane_mask[i] = (i < p) && (len_mod == 0 || i < len_mod);
  endfunction
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi, lo;
    hi = (SAT_W'(1) << (w - 1)) - 1;
    lo = ~hi;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/axi_stream_if.sv
// axi_stream_if: valid/ready stream carrying one flat data word per beat
interface axi_stream_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/vector_ram_if.sv
// vector_ram_if: multi-lane vector RAM port, in-order request/response
interface vector_ram_if #(parameter int ADDR_WIDTH = 5, parameter int DATA_WIDTH = 32, parameter int LANES = 4);
  logic [LANES-1:0][ADDR_WIDTH-1:0] addr;
  logic [LANES-1:0][DATA_WIDTH-1:0] wdata;
  logic [LANES-1:0][DATA_WIDTH-1:0] rdata;
  logic valid, ready, write, rvalid, rready;
  modport master(output addr, wdata, valid, write, rready, input ready, rdata, rvalid);
  modport slave(input addr, wdata, valid, write, rready, output ready, rdata, rvalid);
endinterface

// File: rtl/spmv_val_fifo.sv
// spmv_val_fifo: holds issued value beats and lane masks until their x reads return
module spmv_val_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int PARALLELISM = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] din_val,
  input  logic [PARALLELISM-1:0] din_mask,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] dout_val,
  output logic [PARALLELISM-1:0] dout_mask,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = PARALLELISM * DATA_WIDTH + PARALLELISM;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign {dout_mask, dout_val} = mem[rd_ptr[PW-1:0]];
  // pointers reset; storage is only read behind the write pointer so it needs none
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) mem[wr_ptr[PW-1:0]] <= {din_mask, din_val};
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/spmv_row_engine.sv
// spmv_row_engine: CSR y = A*x one row at a time; SPMV_SATURATE_EN selects clamping instead of wrap
module spmv_row_engine
  import spmv_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH = 2 * DATA_WIDTH,
  parameter int PARALLELISM = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [ADDR_WIDTH:0] num_rows,
  output logic busy,
  output logic done,
  output logic err,
  axi_stream_if.slave r_beg,
  axi_stream_if.slave val,
  axi_stream_if.slave c_idx,
  vector_ram_if.master x,
  vector_ram_if.master y
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int TW = PROD_W + $clog2(PARALLELISM) + 1;
  spmv_engine_state_e state;
  logic [ADDR_WIDTH:0] rows, row;
  logic [DATA_WIDTH-1:0] prev_ptr, cur_ptr, rem, ptr_in, result;
  logic signed [ACC_WIDTH-1:0] acc, acc_next;
  logic signed [TW-1:0] tree_sum, tree_q;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] f_val;
  logic [PARALLELISM-1:0] f_mask, beat_mask;
  logic tree_v, f_full, f_empty, pop, issue, last_beat, r_hs, y_hs;
  assign ptr_in = r_beg.data[DATA_WIDTH-1:0];
  assign r_hs = r_beg.valid && r_beg.ready;
  assign pop = x.rvalid && x.rready;
  assign last_beat = rem <= DATA_WIDTH'(PARALLELISM);
  assign beat_mask = last_beat ? PARALLELISM'(lane_mask(rem < DATA_WIDTH'(PARALLELISM) ? int'(rem) : 0, PARALLELISM)) : '1;
  assign busy = state != IDLE;
  assign r_beg.ready = state == PTR0 || state == PTR;
  assign x.valid = state == ISSUE && val.valid && c_idx.valid && (!f_full || pop);
  assign issue = x.valid && x.ready;
  assign val.ready = issue;
  assign c_idx.ready = issue;
  assign x.rready = !f_empty;
  assign x.write = 1'b0;
  assign x.wdata = '0;
  assign y.valid = state == WRITE;
  assign y.write = 1'b1;
  assign y.rready = 1'b0;
  assign y_hs = y.valid && y.ready;
`ifdef SPMV_SATURATE_EN
  logic signed [ACC_WIDTH:0] acc_sum;
  assign acc_sum = (ACC_WIDTH + 1)'(acc) + (ACC_WIDTH + 1)'(tree_q);
  assign acc_next = ACC_WIDTH'(saturate(SAT_W'(acc_sum), ACC_WIDTH));
  assign result = DATA_WIDTH'(saturate(SAT_W'(acc), DATA_WIDTH));
`else
  assign acc_next = acc + ACC_WIDTH'(tree_q);
  assign result = acc[DATA_WIDTH-1:0];
`endif
  // gather addresses come straight from the low bits of each column-index lane
  always_comb begin
    x.addr = '0;
    for (int i = 0; i < PARALLELISM; i++) x.addr[i] = c_idx.data[i*DATA_WIDTH +: ADDR_WIDTH];
  end
  // y uses lane 0 only: address is the row number, data the reduced accumulator
  always_comb begin
    y.addr = '0;
    y.wdata = '0;
    y.addr[0] = row[ADDR_WIDTH-1:0];
    y.wdata[0] = result;
  end
  // masked full-width lane products summed for the returning beat
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < PARALLELISM; i++)
      tree_sum = tree_sum + (f_mask[i] ? TW'(PROD_W'(signed'(f_val[i])) * PROD_W'(signed'(x.rdata[i]))) : '0);
  end
  spmv_val_fifo #(.DATA_WIDTH(DATA_WIDTH), .PARALLELISM(PARALLELISM), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .rst, .push(issue), .pop, .din_val(val.data), .din_mask(beat_mask),
    .dout_val(f_val), .dout_mask(f_mask), .full(f_full), .empty(f_empty)
  );
  // row sequencing, pointer tracking and the two-stage reduce/accumulate pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rows <= '0;
      row <= '0;
      prev_ptr <= '0;
      cur_ptr <= '0;
      rem <= '0;
      acc <= '0;
      tree_q <= '0;
      tree_v <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      tree_v <= pop;
      if (pop) tree_q <= tree_sum;
      if (tree_v) acc <= acc_next;
      case (state)
        IDLE: if (en) begin
          rows <= num_rows;
          row <= '0;
          err <= 1'b0;
          acc <= '0;
          state <= PTR0;
        end
        PTR0: if (r_hs) begin
          prev_ptr <= ptr_in;
          done <= rows == '0;
          state <= rows == '0 ? IDLE : PTR;
        end
        PTR: if (r_hs) begin
          cur_ptr <= ptr_in;
          rem <= ptr_in - prev_ptr;
          if (ptr_in < prev_ptr) err <= 1'b1;
          state <= ptr_in > prev_ptr ? ISSUE : WRITE;
        end
        ISSUE: if (issue) begin
          rem <= rem - DATA_WIDTH'(PARALLELISM);
          state <= last_beat ? DRAIN : ISSUE;
        end
        DRAIN: state <= f_empty && !tree_v ? WRITE : DRAIN;
        WRITE: if (y_hs) begin
          acc <= '0;
          prev_ptr <= cur_ptr;
          row <= row + 1'b1;
          done <= row + 1'b1 == rows;
          state <= row + 1'b1 == rows ? IDLE : PTR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spmv_row_engine.sv
// tb_spmv_row_engine: randomized CSR runs checked against a plain row-sum reference model
module tb_spmv_row_engine;
  localparam int LEN = 32, DW = 32, P = 4, DEPTH = 4, AW = $clog2(LEN);
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [AW:0] num_rows = '0;
  logic busy, done, err;
  axi_stream_if #(.WIDTH(P*DW)) rb_if ();
  axi_stream_if #(.WIDTH(P*DW)) val_if ();
  axi_stream_if #(.WIDTH(P*DW)) cidx_if ();
  vector_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(P)) x_if ();
  vector_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(P)) y_if ();
  spmv_row_engine #(.LENGTH(LEN), .DATA_WIDTH(DW), .PARALLELISM(P), .FIFO_DEPTH(DEPTH)) dut (
    .clk, .rst, .en, .num_rows, .busy, .done, .err,
    .r_beg(rb_if), .val(val_if), .c_idx(cidx_if), .x(x_if), .y(y_if)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0, stall = 0, n_wr = 0, n_done = 0;
  int rb[$], nzc[$];
  logic signed [DW-1:0] nzv[$];
  logic signed [DW-1:0] xv [LEN];
  logic [P*DW-1:0] rb_q[$], val_q[$], cidx_q[$];
  logic [P-1:0][DW-1:0] resp_q[$];
  logic [DW-1:0] got_y [LEN];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit go();
    return $urandom_range(0, 3) >= stall;
  endfunction

  function automatic logic [P*DW-1:0] rnd_word();
    logic [P*DW-1:0] w;
    for (int l = 0; l < P; l++) w[l*DW +: DW] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] ref_y(input int r);
    longint s = 0, hi, lo;
    for (int k = rb[r]; k < rb[r+1]; k++) s += longint'(nzv[k]) * longint'(xv[nzc[k]]);
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -hi - 1;
`ifdef SPMV_SATURATE_EN
    s = s > hi ? hi : (s < lo ? lo : s);
`endif
    return s[DW-1:0];
  endfunction

  task automatic build_streams();
    logic [P*DW-1:0] w, vw, cw;
    rb_q.delete(); val_q.delete(); cidx_q.delete();
    foreach (rb[i]) begin
      w = rnd_word();
      w[DW-1:0] = rb[i];
      rb_q.push_back(w);
    end
    for (int r = 0; r + 1 < rb.size(); r++)
      for (int k = rb[r]; k < rb[r+1]; k += P) begin
        vw = rnd_word();
        cw = rnd_word();
        for (int l = 0; l < P; l++)
          if (k + l < rb[r+1]) begin
            vw[l*DW +: DW] = nzv[k+l];
            cw[l*DW +: DW] = nzc[k+l];
          end
        val_q.push_back(vw);
        cidx_q.push_back(cw);
      end
  endtask

  task automatic start_run(input string tag, input bit extra_en);
    build_streams();
    foreach (got_y[i]) got_y[i] = 'x;
    n_wr = 0;
    n_done = 0;
    @(negedge clk);
    en = 1'b1;
    num_rows = (AW+1)'(rb.size() - 1);
    @(negedge clk);
    en = 1'b0;
    check({tag, ".err_clr"}, err, 0);
    if (extra_en) begin
      repeat (2) @(negedge clk);
      if (busy) begin
        en = 1'b1;
        num_rows = 1;
        @(negedge clk);
        en = 1'b0;
        num_rows = (AW+1)'(rb.size() - 1);
      end
    end
  endtask

  task automatic finish_run(input string tag);
    int nr = rb.size() - 1;
    bit exp_err = 0;
    for (int r = 0; r < nr; r++) if (rb[r+1] < rb[r]) exp_err = 1;
    for (int c = 0; c < 4000 && n_done == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, ".done_once"}, n_done, 1);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".writes"}, n_wr, nr);
    check({tag, ".streams_used"}, rb_q.size() + val_q.size() + cidx_q.size(), 0);
    for (int r = 0; r < nr; r++) check($sformatf("%s.y%0d", tag, r), got_y[r], ref_y(r));
  endtask

  task automatic rand_matrix();
    int nr = $urandom_range(1, 8), mx = 0, nxt;
    rb.delete(); nzv.delete(); nzc.delete();
    rb.push_back(0);
    for (int r = 0; r < nr; r++) begin
      nxt = $urandom_range(0, 7) == 0 ? (rb[$] > 2 ? rb[$] - 2 : 0) : rb[$] + $urandom_range(0, 9);
      rb.push_back(nxt);
      if (nxt > mx) mx = nxt;
    end
    for (int k = 0; k < mx; k++) begin
      nzv.push_back(DW'($urandom_range(0, 2000)) - 1000);
      nzc.push_back($urandom_range(0, LEN - 1));
    end
    foreach (xv[i]) xv[i] = DW'($urandom_range(0, 2000)) - 1000;
  endtask

  // stream sources, x RAM and y sink: handshakes sampled mid-cycle, applied after the edge
  initial begin
    logic hr, hv, hc, hq, hx;
    logic [P-1:0][DW-1:0] rd;
    rb_if.valid = 0; val_if.valid = 0; cidx_if.valid = 0;
    rb_if.data = '0; val_if.data = '0; cidx_if.data = '0;
    x_if.ready = 0; x_if.rvalid = 0; x_if.rdata = '0;
    y_if.ready = 0; y_if.rvalid = 0; y_if.rdata = '0;
    forever begin
      @(negedge clk);
      hr = rb_if.valid && rb_if.ready;
      hv = val_if.valid && val_if.ready;
      hc = cidx_if.valid && cidx_if.ready;
      hq = x_if.valid && x_if.ready;
      hx = x_if.rvalid && x_if.rready;
      if (done) n_done++;
      if (y_if.valid && y_if.ready) begin
        got_y[y_if.addr[0]] = y_if.wdata[0];
        n_wr++;
      end
      for (int l = 0; l < P; l++) rd[l] = xv[x_if.addr[l]];
      @(posedge clk);
      #1;
      if (rst) begin
        rb_q.delete(); val_q.delete(); cidx_q.delete(); resp_q.delete();
      end else begin
        if (hr) void'(rb_q.pop_front());
        if (hv) void'(val_q.pop_front());
        if (hc) void'(cidx_q.pop_front());
        if (hx) void'(resp_q.pop_front());
        if (hq) resp_q.push_back(rd);
      end
      if (rst || hr || !rb_if.valid) rb_if.valid = rb_q.size() > 0 && go();
      if (rst || hv || !val_if.valid) val_if.valid = val_q.size() > 0 && go();
      if (rst || hc || !cidx_if.valid) cidx_if.valid = cidx_q.size() > 0 && go();
      if (rst || hx || !x_if.rvalid) x_if.rvalid = resp_q.size() > 0 && go();
      rb_if.data = rb_q.size() > 0 ? rb_q[0] : '0;
      val_if.data = val_q.size() > 0 ? val_q[0] : '0;
      cidx_if.data = cidx_q.size() > 0 ? cidx_q[0] : '0;
      x_if.rdata = resp_q.size() > 0 ? resp_q[0] : '0;
      x_if.ready = go();
      y_if.ready = go();
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    check("rst.rb_ready", rb_if.ready, 0);
    check("rst.x_valid", x_if.valid, 0);
    check("rst.y_valid", y_if.valid, 0);
    check("rst.x_rready", x_if.rready, 0);
    #1 rst = 1'b0;
    foreach (xv[i]) xv[i] = DW'($urandom_range(0, 100));
    for (int i = 0; i < 4; i++) xv[i] = i + 1;
    rb = {0, 1, 2, 3, 4}; nzv = {1, 1, 1, 1}; nzc = {0, 1, 2, 3};
    start_run("ident", 0);
    finish_run("ident");
    foreach (xv[i]) xv[i] = 3;
    rb = {0, 6}; nzv = {2, 2, 2, 2, 2, 2}; nzc = {0, 1, 2, 3, 4, 5};
    start_run("len6", 0);
    finish_run("len6");
    check("len6.const", got_y[0], 36);
    foreach (xv[i]) xv[i] = DW'($urandom_range(0, 50));
    rb = {0, 0, 2, 2}; nzv = {5, -7}; nzc = {4, 9};
    start_run("empty", 0);
    finish_run("empty");
    rb = {0, 3, 1}; nzv = {1, 2, 3}; nzc = {1, 2, 3};
    start_run("err", 0);
    finish_run("err");
    rb = {0, 1}; nzv = {32'sh7FFF_FFFF}; nzc = {9}; xv[9] = 2;
    start_run("sat", 0);
    finish_run("sat");
`ifdef SPMV_SATURATE_EN
    check("sat.const", got_y[0], 64'h7FFF_FFFF);
`else
    check("sat.const", got_y[0], 64'hFFFF_FFFE);
`endif
    rb = {11};
    start_run("zero", 0);
    finish_run("zero");
    for (int t = 0; t < 8; t++) begin
      stall = $urandom_range(0, 3);
      rand_matrix();
      start_run($sformatf("rnd%0d", t), 1);
      finish_run($sformatf("rnd%0d", t));
    end
    stall = 2;
    rb = {0, 40};
    nzv.delete(); nzc.delete();
    for (int k = 0; k < 40; k++) begin
      nzv.push_back(DW'($urandom_range(1, 9)));
      nzc.push_back($urandom_range(0, LEN - 1));
    end
    start_run("midrst", 0);
    for (int c = 0; c < 200 && !x_if.valid; c++) @(negedge clk);
    check("midrst.in_issue", x_if.valid, 1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst.busy", busy, 0);
    check("midrst.rb_ready", rb_if.ready, 0);
    check("midrst.x_valid", x_if.valid, 0);
    check("midrst.y_valid", y_if.valid, 0);
    #1 rst = 1'b0;
    rand_matrix();
    start_run("fresh", 0);
    finish_run("fresh");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
